// File: rtl/load_val_controller_pkg.sv
// Shared definitions for the letter/underline redraw path.
// Holds the sequencer state encoding and the pass-length constants that the
// datapath also uses for its segment boundaries.
package load_val_controller_pkg;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = S_IDLE,
      CLEAR = S_CLEAR,
      RUN   = S_RUN,
      FLUSH = S_FLUSH,
      DONE  = S_DONE
   } state_t;

   // Full pass: letter glyph, gap, then underline.
   localparam int DRAW_LEN_DEFAULT = 550;
   localparam int LETTER_DRAW_LEN  = 328;
   localparam int UNDERLINE_START  = 368;
   localparam int UNDERLINE_END    = 385;

   // Bits needed to hold the values 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/load_val_controller_pass_watchdog.sv
// Pass watchdog: counts RUN cycles and flags the last one allowed.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   clear        : zero the count (held in CLEAR)
//   enable       : count this cycle (held in RUN)
//   expired      : this enabled cycle is RUN cycle number TIMEOUT
module load_val_controller_pass_watchdog
   import load_val_controller_pkg::*;
#(
   parameter int TIMEOUT = 1023,
   parameter int CW      = cnt_width(TIMEOUT)
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CW-1:0] count;

   // count holds the RUN cycles already elapsed, so the cycle in which it
   // reads TIMEOUT-1 is the TIMEOUT-th one and must be the last.
   assign expired = enable && (count == CW'(TIMEOUT - 1));

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != CW'(TIMEOUT))) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/load_val_controller.sv
// Redraw sequencer between the game FSM and the letter/underline datapath.
// Accepts redraw requests, clears the datapath counter, enables it until the
// datapath reports done (or the watchdog aborts), and produces the VGA plot
// strobe one cycle behind the enable so it lines up with the registered X/Y.
//
// state | meaning
// IDLE  | waiting for draw_req or a coalesced pending request
// CLEAR | one cycle of dp_reset_n=0 to zero the datapath counter
// RUN   | dp_enable while the datapath is not done; watchdog counting
// FLUSH | one cycle so the last registered pixel is plotted
// DONE  | one cycle draw_done pulse, then back to IDLE
//
// Ports:
//   clock, reset    : system clock, synchronous active-high reset
//   draw_req        : level redraw request
//   letter_num_in   : letter index, captured on accept
//   draw_ack        : pulse on accept
//   busy            : high outside IDLE
//   dp_reset_n      : datapath counter clear (active low)
//   dp_enable       : datapath advance enable
//   dp_done         : datapath terminal flag
//   letter_num_out  : letter index held for the whole pass
//   plot            : VGA write strobe
//   draw_done       : pulse at the end of every pass
//   timeout_err     : sticky abort flag, cleared by reset or next accept
module load_val_controller
   import load_val_controller_pkg::*;
#(
   parameter int DRAW_LEN = DRAW_LEN_DEFAULT,
   parameter int LNUM_W   = 4,
   parameter int TIMEOUT  = 1023
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              draw_req,
   input  logic [LNUM_W-1:0] letter_num_in,
   output logic              draw_ack,
   output logic              busy,
   output logic              dp_reset_n,
   output logic              dp_enable,
   input  logic              dp_done,
   output logic [LNUM_W-1:0] letter_num_out,
   output logic              plot,
   output logic              draw_done,
   output logic              timeout_err
);

   if (DRAW_LEN < 1) begin : g_bad_draw_len
      $error("DRAW_LEN must be at least 1");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("TIMEOUT must be at least 1");
   end

   state_t state;
   state_t state_next;
   logic   pending;
   logic   accept;
   logic   expired;

   // Reset gates accept so no ack is reported for a request that reset discards.
   assign accept     = (state == IDLE) && (draw_req || pending) && !reset;
   assign draw_ack   = accept;
   assign busy       = (state != IDLE);
   assign dp_reset_n = (state != CLEAR);
   // Stop advancing once done so the datapath counter parks at DRAW_LEN.
   assign dp_enable  = (state == RUN) && !dp_done;
   assign draw_done  = (state == DONE);

   load_val_controller_pass_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (state == CLEAR),
      .enable  (state == RUN),
      .expired (expired)
   );

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = CLEAR;
         CLEAR:   state_next = RUN;
         RUN:     if (dp_done || expired) state_next = FLUSH;
         FLUSH:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         pending        <= 1'b0;
         letter_num_out <= '0;
         plot           <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         state <= state_next;
         plot  <= dp_enable;
         if (accept) begin
            letter_num_out <= letter_num_in;
            pending        <= 1'b0;
            timeout_err    <= 1'b0;
         end else begin
            if (busy && draw_req) begin
               pending <= 1'b1;
            end
            // dp_done wins over the watchdog in the same cycle.
            if ((state == RUN) && !dp_done && expired) begin
               timeout_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_load_val_controller.sv
module tb_load_val_controller;
   import load_val_controller_pkg::*;

   localparam int DL   = 550;
   localparam int LW   = 4;
   localparam int TO   = 1023;
   localparam int TO_S = 20;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // main DUT
   logic          reset, draw_req, force_done;
   logic [LW-1:0] lnum_in, lnum_out;
   logic          draw_ack, busy, dp_reset_n, dp_enable, dp_done, plot, draw_done, timeout_err;

   load_val_controller #(.DRAW_LEN(DL), .LNUM_W(LW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .draw_req(draw_req), .letter_num_in(lnum_in),
      .draw_ack(draw_ack), .busy(busy), .dp_reset_n(dp_reset_n), .dp_enable(dp_enable),
      .dp_done(dp_done), .letter_num_out(lnum_out), .plot(plot), .draw_done(draw_done),
      .timeout_err(timeout_err));

   // short-timeout DUT driving a datapath that never finishes
   logic          reset2, req2, dp_done2;
   logic [LW-1:0] lnum_in2, lnum_out2;
   logic          ack2, busy2, rstn2, en2, plot2, done2, terr2;

   load_val_controller #(.DRAW_LEN(DL), .LNUM_W(LW), .TIMEOUT(TO_S)) dut_to (
      .clock(clock), .reset(reset2), .draw_req(req2), .letter_num_in(lnum_in2),
      .draw_ack(ack2), .busy(busy2), .dp_reset_n(rstn2), .dp_enable(en2),
      .dp_done(dp_done2), .letter_num_out(lnum_out2), .plot(plot2), .draw_done(done2),
      .timeout_err(terr2));

   // datapath stand-in: counter 0..DL, pixel sequence number bumps on each enable edge
   int dp_cnt = 0;
   int px_seq = 0;
   assign dp_done = force_done || (dp_cnt == DL);
   always @(posedge clock) begin
      if (!dp_reset_n) dp_cnt <= 0;
      else if (dp_enable && dp_cnt != DL) dp_cnt <= dp_cnt + 1;
      if (dp_enable) px_seq <= px_seq + 1;
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // behavioural model: a pass is described by its accept cycle and the cycle its run phase ended
   bit            m_active = 0, m_pending = 0, m_terr = 0, m_plot = 0, m_run_over = 0;
   int            m_acc = 0, m_end = 0;
   logic [LW-1:0] m_lnum = '0;

   // event logs
   int ack_cyc = -1, first_plot = -1, plot_cnt = 0, done_cyc = -1, ack_seen = 0, done_seen = 0;
   int lnum_at_done = -1, last_plot_seq = -1;
   int ack2_cyc = -1, done2_cyc = -1, en2_cnt = 0, ack2_seen = 0, done2_seen = 0;

   always @(negedge clock) begin
      if (cyc >= 1) begin
         bit e_ack, e_busy, e_rstn, e_en, e_done;
         int off;
         off    = cyc - m_acc;
         e_ack  = 0; e_busy = m_active; e_rstn = 1; e_en = 0; e_done = 0;
         if (!m_active)                e_ack  = !reset && (draw_req || m_pending);
         else if (off == 1)            e_rstn = 0;
         else if (!m_run_over)         e_en   = !dp_done;
         else if (cyc == m_end + 2)    e_done = 1;

         chk("draw_ack", int'(draw_ack), int'(e_ack));
         chk("busy", int'(busy), int'(e_busy));
         chk("dp_reset_n", int'(dp_reset_n), int'(e_rstn));
         chk("dp_enable", int'(dp_enable), int'(e_en));
         chk("draw_done", int'(draw_done), int'(e_done));
         chk("plot", int'(plot), int'(m_plot));
         chk("timeout_err", int'(timeout_err), int'(m_terr));
         chk("letter_num_out", int'(lnum_out), int'(m_lnum));
         if (dp_enable && dp_done) chk("enable while done", 1, 0);
         if (plot) begin
            if (px_seq == last_plot_seq) chk("plot without new pixel", px_seq, last_plot_seq + 1);
            last_plot_seq = px_seq;
         end

         // logs
         if (draw_ack) begin ack_cyc = cyc; ack_seen++; plot_cnt = 0; first_plot = -1; end
         if (plot) begin plot_cnt++; if (first_plot < 0) first_plot = cyc; end
         if (draw_done) begin done_cyc = cyc; done_seen++; lnum_at_done = int'(lnum_out); end
         if (ack2) begin ack2_cyc = cyc; ack2_seen++; en2_cnt = 0; end
         if (en2) en2_cnt++;
         if (done2) begin done2_cyc = cyc; done2_seen++; end

         // advance the model across the coming edge
         if (reset) begin
            m_active = 0; m_pending = 0; m_terr = 0; m_plot = 0; m_lnum = '0;
         end else begin
            m_plot = e_en;
            if (e_ack) begin
               m_active = 1; m_acc = cyc; m_run_over = 0;
               m_pending = 0; m_lnum = lnum_in; m_terr = 0;
            end else if (m_active) begin
               if (draw_req) m_pending = 1;
               if (off >= 2 && !m_run_over) begin
                  if (dp_done) begin
                     m_run_over = 1; m_end = cyc;
                  end else if (cyc - (m_acc + 2) == TO - 1) begin
                     m_run_over = 1; m_end = cyc; m_terr = 1;
                  end
               end else if (m_run_over && cyc == m_end + 2) begin
                  m_active = 0;
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int d0;
      bit seen;
      d0 = done_seen; seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         step(1);
         if (done_seen != d0) seen = 1;
      end
      chk({tag, " draw_done within budget"}, int'(seen), 1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL global time limit reached (cycle %0d)", cyc);
      $fatal(1, "time limit");
   end

   initial begin
      int a, acks, dones, d2;
      bit seen2;
      reset = 1; draw_req = 0; lnum_in = '0; force_done = 0;
      reset2 = 1; req2 = 0; lnum_in2 = '0; dp_done2 = 0;
      repeat (3) @(posedge clock);
      #1; reset = 0; reset2 = 0;                       // cycle 3
      chk("reset busy", int'(busy), 0);
      chk("reset plot", int'(plot), 0);
      chk("reset dp_reset_n", int'(dp_reset_n), 1);
      chk("reset dp_enable", int'(dp_enable), 0);
      chk("reset timeout_err", int'(timeout_err), 0);
      chk("reset letter_num_out", int'(lnum_out), 0);

      // pass 1: request at cycle 5 with letter 3
      step(2);
      draw_req = 1; lnum_in = 3'd3;
      step(1); draw_req = 0;                           // cycle 6 = CLEAR
      chk("pass1 clear dp_reset_n", int'(dp_reset_n), 0);
      step(199);                                       // cycle 205, mid-RUN
      draw_req = 1; lnum_in = 4'd7;
      step(3); draw_req = 0;
      wait_done(600, "pass1");
      chk("pass1 ack cycle", ack_cyc, 5);
      chk("pass1 first plot cycle", first_plot, 8);
      chk("pass1 plot count", plot_cnt, DL);
      chk("pass1 draw_done cycle", done_cyc, 559);
      chk("pass1 letter", lnum_at_done, 3);
      chk("pass1 timeout_err", int'(timeout_err), 0);

      // pass 2: coalesced request accepted one cycle after draw_done
      step(100); lnum_in = 4'd9;
      wait_done(600, "pass2");
      chk("pass2 ack cycle", ack_cyc, 560);
      chk("pass2 draw_done cycle", done_cyc, 1114);
      chk("pass2 letter", lnum_at_done, 7);
      chk("pass2 plot count", plot_cnt, DL);
      chk("acks after two passes", ack_seen, 2);

      // pass 3: reset at RUN cycle 100 with a pending request
      step(3);
      draw_req = 1; step(1); draw_req = 0;
      step(30);
      draw_req = 1; step(1); draw_req = 0;
      step(69);
      reset = 1; step(1); reset = 0;
      chk("post-reset busy", int'(busy), 0);
      chk("post-reset plot", int'(plot), 0);
      chk("post-reset dp_enable", int'(dp_enable), 0);
      acks = ack_seen; dones = done_seen;
      step(20);
      chk("pending dropped by reset", ack_seen, acks);
      chk("no draw_done after reset", done_seen, dones);

      // pass 4: datapath fails to clear, done already high on RUN entry
      force_done = 1; draw_req = 1;
      step(1); draw_req = 0;
      step(3); force_done = 0;
      wait_done(20, "forced");
      chk("forced done after accept", done_cyc - ack_cyc, 4);
      chk("forced plot count", plot_cnt, 0);
      chk("forced timeout_err", int'(timeout_err), 0);

      // random phase
      for (int i = 0; i < 6000; i++) begin
         draw_req   = ($urandom_range(0, 99) < 3);
         lnum_in    = LW'($urandom);
         force_done = ($urandom_range(0, 1999) == 0);
         reset      = ($urandom_range(0, 2999) == 0);
         step(1);
      end
      draw_req = 0; force_done = 0; reset = 0;
      step(1300);
      chk("idle after drain", int'(busy), 0);

      // watchdog abort on the short-timeout instance
      req2 = 1; step(1); req2 = 0;
      d2 = done2_seen; seen2 = 0;
      for (int i = 0; i < 100 && !seen2; i++) begin
         step(1);
         if (done2_seen != d2) seen2 = 1;
      end
      chk("timeout draw_done within budget", int'(seen2), 1);
      chk("timeout enable cycles", en2_cnt, TO_S);
      chk("timeout draw_done after accept", done2_cyc - ack2_cyc, TO_S + 3);
      chk("timeout_err set", int'(terr2), 1);
      step(5);
      chk("timeout_err sticky", int'(terr2), 1);
      req2 = 1;
      chk("timeout_err during accept", int'(terr2), 1);
      step(1); req2 = 0;
      chk("timeout_err cleared by accept", int'(terr2), 0);
      chk("timeout instance accepts", ack2_seen, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
